// File: rtl/video_timing_gen.sv
// Raster timing generator and pixel output stage. It has one CE cycle of latency from the H/V counter to the registered outputs.
// There is no backpressure: the upstream source must supply PIX_* for REQ_X/REQ_Y in the same cycle. VIDEO_TIMING_TEST_PATTERN_EN adds the TEST colour-bar input.
module video_timing_gen #(
    parameter int H_ACTIVE = 720,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 62,
    parameter int H_BP     = 60,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 9,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 30,
    parameter int CNT_W    = 12
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CE,
    input  logic             ENABLE,
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
    input  logic             TEST,
`endif
    output logic [CNT_W-1:0] REQ_X,
    output logic [CNT_W-1:0] REQ_Y,
    output logic             REQ_VALID,
    input  logic [7:0]       PIX_R,
    input  logic [7:0]       PIX_G,
    input  logic [7:0]       PIX_B,
    output logic [7:0]       R,
    output logic [7:0]       G,
    output logic [7:0]       B,
    output logic             HS_n,
    output logic             VS_n,
    output logic             DE,
    output logic             LINE_START,
    output logic             FRAME_START
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG    = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG    = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
    logic [7:0]       r_q, r_d, g_q, g_d, b_q, b_d;
    logic             hs_n_q, hs_n_d, vs_n_q, vs_n_d, de_q, de_d;
    logic             line_start_q, line_start_d, frame_start_q, frame_start_d;

    logic             req_valid;
    logic             in_hsync, in_vsync;
    logic [7:0]       src_r, src_g, src_b;

    assign req_valid = (h_q < H_ACT_END) && (v_q < V_ACT_END);
    assign in_hsync  = (h_q >= HS_BEG) && (h_q < HS_END);
    // The vertical window is decoded from v alone, so VS_n can only change where v does, at h=0.
    assign in_vsync  = (v_q >= VS_BEG) && (v_q < VS_END);

`ifdef VIDEO_TIMING_TEST_PATTERN_EN
    logic [2:0] bar;

    always_comb begin
        bar   = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (h_q >= CNT_W'(i * H_ACTIVE / 8)) begin
                bar = 3'(i);
            end
        end
        src_r = PIX_R;
        src_g = PIX_G;
        src_b = PIX_B;
        if (TEST) begin
            src_r = {8{~bar[1]}};
            src_g = {8{~bar[2]}};
            src_b = {8{~bar[0]}};
        end
    end
`else
    always_comb begin
        src_r = PIX_R;
        src_g = PIX_G;
        src_b = PIX_B;
    end
`endif

    always_comb begin
        h_d           = h_q;
        v_d           = v_q;
        hs_n_d        = hs_n_q;
        vs_n_d        = vs_n_q;
        de_d          = de_q;
        r_d           = r_q;
        g_d           = g_q;
        b_d           = b_q;
        // Strobes fall on every non-CE clock so each lasts exactly one CLK.
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (CE) begin
            if (!ENABLE) begin
                h_d    = '0;
                v_d    = '0;
                hs_n_d = 1'b1;
                vs_n_d = 1'b1;
                de_d   = 1'b0;
                r_d    = 8'h00;
                g_d    = 8'h00;
                b_d    = 8'h00;
            end else begin
                if (h_q == H_LAST) begin
                    h_d = '0;
                    v_d = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
                end else begin
                    h_d = h_q + CNT_W'(1);
                end
                hs_n_d        = ~in_hsync;
                vs_n_d        = ~in_vsync;
                de_d          = req_valid;
                r_d           = req_valid ? src_r : 8'h00;
                g_d           = req_valid ? src_g : 8'h00;
                b_d           = req_valid ? src_b : 8'h00;
                line_start_d  = (h_q == '0);
                frame_start_d = (h_q == '0) && (v_q == '0);
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            h_q           <= '0;
            v_q           <= '0;
            hs_n_q        <= 1'b1;
            vs_n_q        <= 1'b1;
            de_q          <= 1'b0;
            r_q           <= 8'h00;
            g_q           <= 8'h00;
            b_q           <= 8'h00;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            hs_n_q        <= hs_n_d;
            vs_n_q        <= vs_n_d;
            de_q          <= de_d;
            r_q           <= r_d;
            g_q           <= g_d;
            b_q           <= b_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign REQ_X       = h_q;
    assign REQ_Y       = v_q;
    assign REQ_VALID   = req_valid;
    assign R           = r_q;
    assign G           = g_q;
    assign B           = b_q;
    assign HS_n        = hs_n_q;
    assign VS_n        = vs_n_q;
    assign DE          = de_q;
    assign LINE_START  = line_start_q;
    assign FRAME_START = frame_start_q;

endmodule
